logic_unit_seq: RTL and testbench

Parametrised, multi-cycle successor to the 32-bit combinational logic unit. It evaluates one of eight bitwise operations on two WIDTH-bit operands, CHUNK bits per clock, LSB slice first. It accumulates zero and parity flags alongside the result. It sits between the operand register stage and the result bus of the datapath and talks to both sides through valid/ready handshakes.

---
 rtl/logic_unit_seq.sv | 127 ++++++++++++
 tb/tb_logic_unit_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: applies one of eight ops CHUNK bits per clock, LSB slice first,
// accumulating zero and parity flags, with valid/ready handshakes on both sides.
module logic_unit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             parity,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("logic_unit_seq: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_parity;

  logic [CHUNK-1:0] w_sa;
  logic [CHUNK-1:0] w_sb;
  logic [CHUNK-1:0] w_res;
  logic             w_last;

  assign w_last = (r_cnt == CW'(NSLICE - 1));

  // Select the operand slice addressed by the counter.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (r_cnt == CW'(i)) begin
        w_sa = r_a[i*CHUNK +: CHUNK];
        w_sb = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  always_comb begin
    w_res = '0;
    unique case (r_op)
      3'b000:  w_res = ~(w_sa | w_sb);
      3'b001:  w_res = w_sa & w_sb;
      3'b010:  w_res = w_sa | w_sb;
      3'b011:  w_res = w_sa ^ w_sb;
      3'b100:  w_res = ~(w_sa & w_sb);
      3'b101:  w_res = ~(w_sa ^ w_sb);
      3'b110:  w_res = w_sa & ~w_sb;
      default: w_res = w_sa;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (in_valid)  w_state_nxt = StRun;
      StRun:   if (w_last)    w_state_nxt = StDone;
      StDone:  if (out_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_zero   <= 1'b0;
      r_parity <= 1'b0;
    end else if (r_state == StIdle && in_valid) begin
      r_a      <= a;
      r_b      <= b;
      r_op     <= op;
      r_cnt    <= '0;
      r_out    <= '0;
      r_zero   <= 1'b1;
      r_parity <= 1'b0;
    end else if (r_state == StRun) begin
      for (int i = 0; i < NSLICE; i++) begin
        if (r_cnt == CW'(i)) r_out[i*CHUNK +: CHUNK] <= w_res;
      end
      r_zero   <= r_zero & (w_res == '0);
      r_parity <= r_parity ^ (^w_res);
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out    = r_out;
  assign zero   = r_zero;
  assign parity = r_parity;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: default 32/8 instance plus a single-slice 16/16 instance.
module tb_logic_unit_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b, out;
  logic [2:0]  op;
  logic        in_valid, in_ready, zero, parity, out_valid, out_ready;

  logic [15:0] a16, b16, out16;
  logic [2:0]  op16;
  logic        in_valid16, in_ready16, zero16, parity16, out_valid16, out_ready16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logic_unit_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .zero(zero), .parity(parity),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  logic_unit_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .op(op16), .in_valid(in_valid16),
    .in_ready(in_ready16), .out(out16), .zero(zero16), .parity(parity16),
    .out_valid(out_valid16), .out_ready(out_ready16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] top);
    a = ta; b = tb_; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until out_valid; bounded at 20.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                           input logic [2:0] top, input logic [31:0] exp_out,
                           input logic exp_z, input logic exp_p);
    int lat;
    start_op(ta, tb_, top);
    wait_done(lat);
    check_eq({tag, "_lat"}, lat, 4);
    check_eq({tag, "_out"}, out, exp_out);
    check_eq({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
    check_eq({tag, "_par"}, {31'd0, parity}, {31'd0, exp_p});
    release_result();
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
    a16 = '0; b16 = '0; op16 = '0; in_valid16 = 1'b0; out_ready16 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out", out, 32'd0);
    check_eq("rst_flags", {30'd0, zero, parity}, 32'd0);
    check_eq("rst_out16", {16'd0, out16}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    run_check("nor",  32'hA, 32'hC, 3'b000, 32'hFFFF_FFF1, 1'b0, 1'b1);
    run_check("and",  32'hA, 32'hC, 3'b001, 32'h8,         1'b0, 1'b1);
    run_check("or",   32'hA, 32'hC, 3'b010, 32'hE,         1'b0, 1'b1);
    run_check("xor",  32'hA, 32'hC, 3'b011, 32'h6,         1'b0, 1'b0);
    run_check("nand", 32'hA, 32'hC, 3'b100, 32'hFFFF_FFF7, 1'b0, 1'b1);
    run_check("andn", 32'hA, 32'hC, 3'b110, 32'h2,         1'b0, 1'b1);
    run_check("pass", 32'hA, 32'hC, 3'b111, 32'hA,         1'b0, 1'b0);
    run_check("xor_zero", 32'h1234_5678, 32'h1234_5678, 3'b011, 32'h0, 1'b1, 1'b0);
    run_check("xnor_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Operands change during RUN; result must follow the captured values.
    start_op(32'h0F0F_0F0F, 32'h00FF_00FF, 3'b011);
    a = 32'hFFFF_FFFF; b = 32'h0;
    wait_done(lat);
    check_eq("capt_lat", lat, 4);
    check_eq("capt_out", out, 32'h0FF0_0FF0);
    check_eq("capt_par", {31'd0, parity}, 32'd0);

    // Backpressure: hold DONE with a pending request that must be ignored.
    a = 32'h1; b = 32'h1; op = 3'b001; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("hold_out", out, 32'h0FF0_0FF0);
      check_eq("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("ret_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("ret_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("next_accepted", {31'd0, in_ready}, 32'd0);
    wait_done(lat);
    check_eq("next_lat", lat, 4);
    check_eq("next_out", out, 32'h1);
    check_eq("next_par", {31'd0, parity}, 32'd1);
    release_result();

    // Reset mid-RUN after one slice has been written.
    start_op(32'hA, 32'hC, 3'b000);
    @(posedge clk); #1;
    check_eq("mid_partial", out, 32'hF1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mrst_out", out, 32'd0);
    check_eq("mrst_flags", {30'd0, zero, parity}, 32'd0);
    check_eq("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("mrst_no_valid", seen, 0);

    // Single-slice instance.
    a16 = 16'hA; b16 = 16'hC; op16 = 3'b000; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("w16_lat", lat, 1);
    check_eq("w16_out", {16'd0, out16}, 32'hFFF1);
    check_eq("w16_flags", {30'd0, zero16, parity16}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
